alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
// - ID/EX pipeline stage feeding the ALU: registers decoded operands/control, selects
//   forwarded operands, resolves SrcB (reg/imm), detects load-use hazards.
// - Drives the ALU's SrcA, SrcB, PC_Cur, Branch and Operation directly; sits between decode and EX.
// - Inserts bubbles on hazard/flush and counts bubble cycles for performance analysis.
// PARAMETERS
// - DATA_WIDTH     32  operand/result width
// - OPCODE_LENGTH  4   ALU Operation width
// - PC_WIDTH       9   PC width
// - REG_ADDR_W     5   register index width
// - STALL_CNT_W    16  bubble counter width (saturating)
// PORTS
// - clk           in   1            clock, all state on rising edge
// - rst_n         in   1            asynchronous active-low reset
// - id_valid      in   1            decode slot holds a real instruction
// - id_rs1/id_rs2 in   REG_ADDR_W   source indices;  id_rd in REG_ADDR_W destination
// - id_rs1_data   in   DATA_WIDTH   regfile read A;  id_rs2_data in DATA_WIDTH read B
// - id_imm        in   DATA_WIDTH   sign-extended immediate
// - id_alusrc     in   1            1: SrcB=imm, 0: SrcB=rs2 value
// - id_operation  in   OPCODE_LENGTH ALU op;  id_branch in 1;  id_pc in PC_WIDTH
// - id_memread    in   1  load;      id_regwrite in 1  writes rd
// - exm_regwrite  in   1;  exm_rd in REG_ADDR_W;  exm_result in DATA_WIDTH   (EX/MEM)
// - wb_regwrite   in   1;  wb_rd  in REG_ADDR_W;  wb_result  in DATA_WIDTH   (MEM/WB)
// - flush         in   1            kill decode-slot instruction (taken branch/jump)
// - stall         out  1            hold PC and IF/ID this cycle (combinational)
// - SrcA, SrcB    out  DATA_WIDTH   ALU operands (forwarded, combinational from EX regs)
// - PC_Cur        out  PC_WIDTH;  Branch out 1;  Operation out OPCODE_LENGTH
// - ex_store_data out  DATA_WIDTH   forwarded rs2 value for stores
// - ex_valid, ex_regwrite, ex_memread out 1;  ex_rd out REG_ADDR_W
// - bubble_cnt    out  STALL_CNT_W  bubbles injected since reset
// BEHAVIOUR
// - Reset (async, rst_n=0): all EX registers 0 (ex_valid=0, Operation=4'b0000, Branch=0,
//   PC_Cur=0, ex_rd=0), bubble_cnt=0; stall=0 while in reset. Reset mid-stream drops in-flight op.
// - Latency 1: ID inputs captured on rising edge appear at EX outputs next cycle.
// - Load-use hazard (hz): ex_valid & ex_memread & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
// - Per edge, priority: flush > hz > normal.
//   flush: EX <= bubble; stall=0.   hz: EX <= bubble; stall=1 (ID held, re-presented next cycle).
//   normal: EX <= ID fields; ex_valid<=id_valid; id_valid=0 loads a bubble.
// - Bubble: ex_valid=0, ex_regwrite=0, ex_memread=0, Branch=0, Operation=0, ex_rd=0.
// - bubble_cnt +1 on every edge that loads a bubble due to flush or hz (not id_valid=0);
//   saturates at all-ones.
// - Forwarding (per EX source rsX): if exm_regwrite & exm_rd!=0 & exm_rd==rsX -> exm_result;
//   elif wb_regwrite & wb_rd!=0 & wb_rd==rsX -> wb_result; else registered regfile data.
//   EX/MEM wins over MEM/WB when both match. x0 never forwarded.
// - SrcA = fwd(rs1); ex_store_data = fwd(rs2); SrcB = alusrc ? imm : fwd(rs2).
// CONFIGURATION
// - ALU_OPERAND_FWD_EN defined: forwarding as above; hz as above (max 1 bubble).
// - Not defined: no forwarding (SrcA/SrcB from registered regfile data); hz becomes any
//   id_valid source (rs!=0) matching rd of a valid writer in EX, EX/MEM or MEM/WB; stall and
//   bubble each cycle it holds (up to 3 consecutive). Flush priority and counter unchanged.
// TESTING
// - Reset: rst_n=0 mid-op with ex_valid=1 -> all outputs 0 immediately; bubble_cnt=0.
// - Fwd priority (FWD_EN): EX rs1=5, exm_rd=5/exm_result=0x11, wb_rd=5/wb_result=0x22 -> SrcA=0x11.
// - Load-use: EX lw rd=7; ID add rs2=7 -> stall=1 one cycle, ex_valid=0, bubble_cnt=1; add issues next.
// - Flush+hz same cycle: -> stall=0, EX bubble, bubble_cnt+1, ID instruction never reaches EX.
// - x0/imm: id_rs1=0 with exm_rd=0 exm_regwrite=1 exm_result=0xFF -> SrcA=id_rs1_data;
//   id_alusrc=1 id_imm=0xFFFFFFFC -> SrcB=0xFFFFFFFC.
// - No FWD_EN: addi x3 then add rs1=x3 back-to-back -> 3 stall cycles, then SrcA=regfile value.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// ID/EX pipeline register in front of the ALU. Captures decoded operands and
// control, resolves operand forwarding from EX/MEM and MEM/WB, selects SrcB
// between the register value and the immediate, and detects data hazards that
// require holding decode for a cycle. Every edge that injects a bubble because
// of a flush or a hazard bumps a saturating performance counter.
//
// Build option: define ALU_OPERAND_FWD_EN to enable result forwarding. With it
// only a load immediately followed by a consumer stalls (one bubble). Without
// it, any source register still pending in EX, EX/MEM or MEM/WB stalls decode
// until the writer has retired (up to three bubbles in a row).
module alu_operand_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int PC_WIDTH      = 9,
    parameter int REG_ADDR_W    = 5,
    parameter int STALL_CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,

    // decode slot
    input  logic                     id_valid,
    input  logic [REG_ADDR_W-1:0]    id_rs1,
    input  logic [REG_ADDR_W-1:0]    id_rs2,
    input  logic [REG_ADDR_W-1:0]    id_rd,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic                     id_alusrc,
    input  logic [OPCODE_LENGTH-1:0] id_operation,
    input  logic                     id_branch,
    input  logic [PC_WIDTH-1:0]      id_pc,
    input  logic                     id_memread,
    input  logic                     id_regwrite,

    // EX/MEM writeback candidate
    input  logic                     exm_regwrite,
    input  logic [REG_ADDR_W-1:0]    exm_rd,
    input  logic [DATA_WIDTH-1:0]    exm_result,

    // MEM/WB writeback candidate
    input  logic                     wb_regwrite,
    input  logic [REG_ADDR_W-1:0]    wb_rd,
    input  logic [DATA_WIDTH-1:0]    wb_result,

    input  logic                     flush,
    output logic                     stall,

    // ALU-facing EX outputs
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [PC_WIDTH-1:0]      PC_Cur,
    output logic                     Branch,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic                     ex_valid,
    output logic                     ex_regwrite,
    output logic                     ex_memread,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic [STALL_CNT_W-1:0]   bubble_cnt
);

    localparam logic [REG_ADDR_W-1:0]  REG_ZERO = '0;
    localparam logic [STALL_CNT_W-1:0] CNT_ONE  = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_W-1:0] CNT_MAX  = {STALL_CNT_W{1'b1}};

    genvar gi;

    // ------------------------------------------------------------------
    // EX stage registers
    // ------------------------------------------------------------------
    logic                     ex_valid_reg;
    logic                     ex_regwrite_reg;
    logic                     ex_memread_reg;
    logic                     ex_branch_reg;
    logic [OPCODE_LENGTH-1:0] ex_operation_reg;
    logic [PC_WIDTH-1:0]      ex_pc_reg;
    logic [REG_ADDR_W-1:0]    ex_rd_reg;
    logic [REG_ADDR_W-1:0]    ex_rs1_reg;
    logic [REG_ADDR_W-1:0]    ex_rs2_reg;
    logic [DATA_WIDTH-1:0]    ex_rs1_data_reg;
    logic [DATA_WIDTH-1:0]    ex_rs2_data_reg;
    logic [DATA_WIDTH-1:0]    ex_imm_reg;
    logic                     ex_alusrc_reg;
    logic [STALL_CNT_W-1:0]   bubble_cnt_reg;

    // Decode and EX source indices packed so both operands share one
    // generate loop.
    logic [1:0][REG_ADDR_W-1:0] id_src;
    logic [1:0][REG_ADDR_W-1:0] ex_src;
    logic [1:0][DATA_WIDTH-1:0] ex_src_data;
    logic [1:0][DATA_WIDTH-1:0] fwd_data;

    assign id_src[0]      = id_rs1;
    assign id_src[1]      = id_rs2;
    assign ex_src[0]      = ex_rs1_reg;
    assign ex_src[1]      = ex_rs2_reg;
    assign ex_src_data[0] = ex_rs1_data_reg;
    assign ex_src_data[1] = ex_rs2_data_reg;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic hazard;
    logic load_bubble;
    logic issue;

`ifdef ALU_OPERAND_FWD_EN
    // Only a load sitting in EX cannot be forwarded in time: its data is
    // still in memory when the consumer would enter EX.
    logic [1:0] src_hit;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_load_use
            assign src_hit[gi] = (ex_rd_reg == id_src[gi]);
        end
    endgenerate

    assign hazard = id_valid & ex_valid_reg & ex_memread_reg &
                    (ex_rd_reg != REG_ZERO) & (|src_hit);
`else
    // Without forwarding a source is unusable until its writer has left
    // MEM/WB, so any pending writer downstream blocks decode. x0 is never
    // pending because it is hardwired.
    logic [1:0] src_busy;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_busy
            logic ex_pending;
            logic exm_pending;
            logic wb_pending;

            assign ex_pending  = ex_valid_reg & ex_regwrite_reg & (ex_rd_reg == id_src[gi]);
            assign exm_pending = exm_regwrite & (exm_rd == id_src[gi]);
            assign wb_pending  = wb_regwrite & (wb_rd == id_src[gi]);
            assign src_busy[gi] = (id_src[gi] != REG_ZERO) &
                                  (ex_pending | exm_pending | wb_pending);
        end
    endgenerate

    assign hazard = id_valid & (|src_busy);
`endif

    // A flush kills the decode slot outright, so it overrides the hazard and
    // there is nothing to hold.
    assign load_bubble = flush | hazard;
    assign issue       = id_valid & ~load_bubble;
    assign stall       = rst_n & hazard & ~flush;

    // ------------------------------------------------------------------
    // Operand forwarding
    // ------------------------------------------------------------------
`ifdef ALU_OPERAND_FWD_EN
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic exm_hit;
            logic wb_hit;

            // The younger result (EX/MEM) is the architecturally newest value.
            assign exm_hit = exm_regwrite & (exm_rd != REG_ZERO) & (exm_rd == ex_src[gi]);
            assign wb_hit  = wb_regwrite  & (wb_rd  != REG_ZERO) & (wb_rd  == ex_src[gi]);
            assign fwd_data[gi] = exm_hit ? exm_result :
                                  (wb_hit ? wb_result : ex_src_data[gi]);
        end
    endgenerate
`else
    // Hazard stalls guarantee the regfile read is already up to date.
    logic unused_fwd_inputs;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_nofwd
            assign fwd_data[gi] = ex_src_data[gi];
        end
    endgenerate

    assign unused_fwd_inputs = ^{exm_result, wb_result, ex_src};
`endif

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Control fields: load the decoded instruction or collapse to a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg     <= 1'b0;
            ex_regwrite_reg  <= 1'b0;
            ex_memread_reg   <= 1'b0;
            ex_branch_reg    <= 1'b0;
            ex_operation_reg <= '0;
            ex_rd_reg        <= '0;
        end else if (issue) begin
            ex_valid_reg     <= 1'b1;
            ex_regwrite_reg  <= id_regwrite;
            ex_memread_reg   <= id_memread;
            ex_branch_reg    <= id_branch;
            ex_operation_reg <= id_operation;
            ex_rd_reg        <= id_rd;
        end else begin
            ex_valid_reg     <= 1'b0;
            ex_regwrite_reg  <= 1'b0;
            ex_memread_reg   <= 1'b0;
            ex_branch_reg    <= 1'b0;
            ex_operation_reg <= '0;
            ex_rd_reg        <= '0;
        end
    end

    // Operand fields: cleared on bubbles so idle EX drives quiet zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_pc_reg       <= '0;
            ex_rs1_reg      <= '0;
            ex_rs2_reg      <= '0;
            ex_rs1_data_reg <= '0;
            ex_rs2_data_reg <= '0;
            ex_imm_reg      <= '0;
            ex_alusrc_reg   <= 1'b0;
        end else if (issue) begin
            ex_pc_reg       <= id_pc;
            ex_rs1_reg      <= id_rs1;
            ex_rs2_reg      <= id_rs2;
            ex_rs1_data_reg <= id_rs1_data;
            ex_rs2_data_reg <= id_rs2_data;
            ex_imm_reg      <= id_imm;
            ex_alusrc_reg   <= id_alusrc;
        end else begin
            ex_pc_reg       <= '0;
            ex_rs1_reg      <= '0;
            ex_rs2_reg      <= '0;
            ex_rs1_data_reg <= '0;
            ex_rs2_data_reg <= '0;
            ex_imm_reg      <= '0;
            ex_alusrc_reg   <= 1'b0;
        end
    end

    // Count bubbles forced by flush or hazard; an empty decode slot is not lost work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_reg <= '0;
        end else if (load_bubble && (bubble_cnt_reg != CNT_MAX)) begin
            bubble_cnt_reg <= bubble_cnt_reg + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign SrcA          = fwd_data[0];
    assign ex_store_data = fwd_data[1];
    assign SrcB          = ex_alusrc_reg ? ex_imm_reg : fwd_data[1];
    assign PC_Cur        = ex_pc_reg;
    assign Branch        = ex_branch_reg;
    assign Operation     = ex_operation_reg;
    assign ex_valid      = ex_valid_reg;
    assign ex_regwrite   = ex_regwrite_reg;
    assign ex_memread    = ex_memread_reg;
    assign ex_rd         = ex_rd_reg;
    assign bubble_cnt    = bubble_cnt_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: directed scenarios with literal expectations,
// then a randomized run compared every cycle against a behavioural model.
// Honours ALU_OPERAND_FWD_EN the same way the design does.
module tb_alu_operand_stage;

    localparam int DW      = 32;
    localparam int OPL     = 4;
    localparam int PCW     = 9;
    localparam int RAW     = 5;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            id_valid;
    logic [RAW-1:0]  id_rs1, id_rs2, id_rd;
    logic [DW-1:0]   id_rs1_data, id_rs2_data, id_imm;
    logic            id_alusrc;
    logic [OPL-1:0]  id_operation;
    logic            id_branch;
    logic [PCW-1:0]  id_pc;
    logic            id_memread, id_regwrite;
    logic            exm_regwrite;
    logic [RAW-1:0]  exm_rd;
    logic [DW-1:0]   exm_result;
    logic            wb_regwrite;
    logic [RAW-1:0]  wb_rd;
    logic [DW-1:0]   wb_result;
    logic            flush;
    logic            stall;
    logic [DW-1:0]   SrcA, SrcB, ex_store_data;
    logic [PCW-1:0]  PC_Cur;
    logic            Branch;
    logic [OPL-1:0]  Operation;
    logic            ex_valid, ex_regwrite, ex_memread;
    logic [RAW-1:0]  ex_rd;
    logic [CW-1:0]   bubble_cnt;

    alu_operand_stage #(
        .DATA_WIDTH(DW), .OPCODE_LENGTH(OPL), .PC_WIDTH(PCW),
        .REG_ADDR_W(RAW), .STALL_CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_operation(id_operation), .id_branch(id_branch),
        .id_pc(id_pc), .id_memread(id_memread), .id_regwrite(id_regwrite),
        .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .flush(flush), .stall(stall),
        .SrcA(SrcA), .SrcB(SrcB), .PC_Cur(PC_Cur), .Branch(Branch),
        .Operation(Operation), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alusrc = 0;
        id_operation = 0; id_branch = 0; id_pc = 0; id_memread = 0; id_regwrite = 0;
        exm_regwrite = 0; exm_rd = 0; exm_result = 0;
        wb_regwrite = 0; wb_rd = 0; wb_result = 0;
        flush = 0;
    endtask

    task automatic put_id(input logic [RAW-1:0] rs1, input logic [RAW-1:0] rs2,
                          input logic [RAW-1:0] rd, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input logic [DW-1:0] imm,
                          input logic alusrc, input logic [OPL-1:0] op,
                          input logic memread, input logic regwrite);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alusrc = alusrc;
        id_operation = op; id_branch = 0; id_pc = 9'h010; id_memread = memread;
        id_regwrite = regwrite;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: the instruction currently held in EX, and the
    // number of lost slots.
    // ------------------------------------------------------------------
    typedef struct {
        bit           valid, regwrite, memread, branch, alusrc;
        bit [OPL-1:0] op;
        bit [PCW-1:0] pc;
        bit [RAW-1:0] rd, rs1, rs2;
        bit [DW-1:0]  d1, d2, imm;
    } ex_t;

    ex_t m, nxt;
    int  m_cnt;

`ifdef ALU_OPERAND_FWD_EN
    // Newest in-flight value of register r, else the regfile read.
    function automatic bit [DW-1:0] model_fwd(input bit [RAW-1:0] r, input bit [DW-1:0] d);
        if (exm_regwrite && exm_rd != 0 && exm_rd == r) return exm_result;
        if (wb_regwrite && wb_rd != 0 && wb_rd == r) return wb_result;
        return d;
    endfunction
`else
    // Register r still has a write in flight somewhere downstream.
    function automatic bit pending(input bit [RAW-1:0] r);
        if (r == 0) return 0;
        return (m.valid && m.regwrite && m.rd == r) ||
               (exm_regwrite && exm_rd == r) || (wb_regwrite && wb_rd == r);
    endfunction
`endif

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    bit             hold;
    bit             hz;
    bit             exp_stall;
    bit [DW-1:0]    exp_a, exp_store;
    int             stalls;

    initial begin
        idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();

        // ---------- reset mid-operation ----------
        put_id(5'd1, 5'd2, 5'd4, 32'h1, 32'h2, 32'h0, 1'b0, 4'h5, 1'b0, 1'b1);
        id_branch = 1; id_pc = 9'h123;
        tick();
        check("pre_reset_ex_valid", 32'(ex_valid), 32'd1);
        check("pre_reset_op", 32'(Operation), 32'h5);
        check("pre_reset_pc", 32'(PC_Cur), 32'h123);
        #2 rst_n = 0;
        #1;
        check("reset_ex_valid", 32'(ex_valid), 32'd0);
        check("reset_op", 32'(Operation), 32'd0);
        check("reset_branch", 32'(Branch), 32'd0);
        check("reset_pc", 32'(PC_Cur), 32'd0);
        check("reset_rd", 32'(ex_rd), 32'd0);
        check("reset_cnt", 32'(bubble_cnt), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        idle();
        tick();
        rst_n = 1;
        tick();

        // ---------- load-use: lw x7 then add using x7 ----------
        put_id(5'd1, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        tick();
        put_id(5'd2, 5'd7, 5'd8, 32'hA, 32'hB, 32'h0, 1'b0, 4'h2, 1'b0, 1'b1);
        settle();
        check("lu_stall", 32'(stall), 32'd1);
        tick();
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_cnt", 32'(bubble_cnt), 32'd1);
        check("lu_stall_clear", 32'(stall), 32'd0);
        tick();
        check("lu_issue_valid", 32'(ex_valid), 32'd1);
        check("lu_issue_rd", 32'(ex_rd), 32'd8);
        check("lu_issue_srca", SrcA, 32'hA);
        check("lu_issue_srcb", SrcB, 32'hB);

        // ---------- flush and hazard in the same cycle ----------
        put_id(5'd1, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        tick();
        put_id(5'd2, 5'd7, 5'd8, 32'hA, 32'hB, 32'h0, 1'b0, 4'h2, 1'b0, 1'b1);
        flush = 1;
        settle();
        check("fl_stall", 32'(stall), 32'd0);
        tick();
        check("fl_bubble_valid", 32'(ex_valid), 32'd0);
        check("fl_cnt", 32'(bubble_cnt), 32'd2);
        idle();
        tick();
        check("fl_never_issued", 32'(ex_valid), 32'd0);
        check("fl_cnt_idle", 32'(bubble_cnt), 32'd2);

        // ---------- x0 never forwarded, immediate SrcB ----------
        put_id(5'd0, 5'd0, 5'd1, 32'h1234, 32'h55, 32'hFFFF_FFFC, 1'b1, 4'h1, 1'b0, 1'b1);
        exm_regwrite = 1; exm_rd = 0; exm_result = 32'hFF;
        tick();
        check("x0_srca", SrcA, 32'h1234);
        check("imm_srcb", SrcB, 32'hFFFF_FFFC);
        check("x0_store", ex_store_data, 32'h55);
        idle();

`ifdef ALU_OPERAND_FWD_EN
        // ---------- forwarding priority ----------
        put_id(5'd5, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        tick();
        idle();
        exm_regwrite = 1; exm_rd = 5; exm_result = 32'h11;
        wb_regwrite = 1;  wb_rd = 5;  wb_result = 32'h22;
        settle();
        check("fwd_exm_wins", SrcA, 32'h11);
        exm_regwrite = 0;
        settle();
        check("fwd_wb", SrcA, 32'h22);
        wb_regwrite = 0;
        settle();
        check("fwd_none", SrcA, 32'h99);
        tick();
`else
        // ---------- no forwarding: addi x3 then add x3 ----------
        stalls = 0;
        put_id(5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h5, 1'b1, 4'h0, 1'b0, 1'b1);
        tick();
        put_id(5'd3, 5'd0, 5'd9, 32'h33, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        settle();
        stalls += int'(stall);
        tick();
        exm_regwrite = 1; exm_rd = 3;
        settle();
        stalls += int'(stall);
        tick();
        exm_regwrite = 0; wb_regwrite = 1; wb_rd = 3;
        settle();
        stalls += int'(stall);
        tick();
        wb_regwrite = 0;
        settle();
        check("nofwd_release", 32'(stall), 32'd0);
        tick();
        check("nofwd_stalls", 32'(stalls), 32'd3);
        check("nofwd_valid", 32'(ex_valid), 32'd1);
        check("nofwd_rd", 32'(ex_rd), 32'd9);
        check("nofwd_srca", SrcA, 32'h33);
        check("nofwd_cnt", 32'(bubble_cnt), 32'd5);
        idle();
`endif

        // ---------- randomized run against the model ----------
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        m = '{default: '0};
        m_cnt = 0;
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!hold) begin
                id_valid     = ($urandom_range(0, 99) < 80);
                id_rs1       = 5'($urandom_range(0, 7));
                id_rs2       = 5'($urandom_range(0, 7));
                id_rd        = 5'($urandom_range(0, 7));
                id_rs1_data  = $urandom;
                id_rs2_data  = $urandom;
                id_imm       = $urandom;
                id_alusrc    = 1'($urandom_range(0, 1));
                id_operation = 4'($urandom_range(0, 15));
                id_branch    = 1'($urandom_range(0, 1));
                id_pc        = 9'($urandom_range(0, 511));
                id_memread   = ($urandom_range(0, 99) < 30);
                id_regwrite  = id_memread ? 1'b1 : ($urandom_range(0, 99) < 70);
            end
            exm_regwrite = ($urandom_range(0, 99) < 30);
            exm_rd       = 5'($urandom_range(0, 7));
            exm_result   = $urandom;
            wb_regwrite  = ($urandom_range(0, 99) < 30);
            wb_rd        = 5'($urandom_range(0, 7));
            wb_result    = $urandom;
            flush        = id_valid && ($urandom_range(0, 99) < 12);

            @(negedge clk);
`ifdef ALU_OPERAND_FWD_EN
            hz = id_valid && m.valid && m.memread && m.rd != 0 &&
                 (m.rd == id_rs1 || m.rd == id_rs2);
`else
            hz = id_valid && (pending(id_rs1) || pending(id_rs2));
`endif
            exp_stall = hz && !flush;
            check("rnd_stall", 32'(stall), 32'(exp_stall));
            check("rnd_ex_valid", 32'(ex_valid), 32'(m.valid));
            check("rnd_regwrite", 32'(ex_regwrite), 32'(m.regwrite));
            check("rnd_memread", 32'(ex_memread), 32'(m.memread));
            check("rnd_branch", 32'(Branch), 32'(m.branch));
            check("rnd_op", 32'(Operation), 32'(m.op));
            check("rnd_rd", 32'(ex_rd), 32'(m.rd));
            check("rnd_cnt", 32'(bubble_cnt), 32'(m_cnt));
            if (m.valid) begin
`ifdef ALU_OPERAND_FWD_EN
                exp_a     = model_fwd(m.rs1, m.d1);
                exp_store = model_fwd(m.rs2, m.d2);
`else
                exp_a     = m.d1;
                exp_store = m.d2;
`endif
                check("rnd_srca", SrcA, exp_a);
                check("rnd_store", ex_store_data, exp_store);
                check("rnd_srcb", SrcB, m.alusrc ? m.imm : exp_store);
                check("rnd_pc", 32'(PC_Cur), 32'(m.pc));
            end

            nxt = '{default: '0};
            if (flush || hz) begin
                if (m_cnt < CNT_MAX) m_cnt++;
            end else if (id_valid) begin
                nxt.valid = 1; nxt.regwrite = id_regwrite; nxt.memread = id_memread;
                nxt.branch = id_branch; nxt.alusrc = id_alusrc; nxt.op = id_operation;
                nxt.pc = id_pc; nxt.rd = id_rd; nxt.rs1 = id_rs1; nxt.rs2 = id_rs2;
                nxt.d1 = id_rs1_data; nxt.d2 = id_rs2_data; nxt.imm = id_imm;
            end
            hold = exp_stall;
            @(posedge clk);
            #1;
            m = nxt;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
